config_loader: RTL and testbench

//  Drives the layer configuration bus (config_in/valid/type/layer_num/neuron_num) consumed by every neuron.

---
 rtl/config_loader.sv | 171 +++++++++++++++++
 tb/tb_config_loader.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// Layer configuration loader: turns a header+payload word stream into per-word
// configuration writes addressed to one neuron's weight or bias memory.
module config_loader #(
   parameter int NUM_LAYERS  = 4,
   parameter int NUM_NEURONS = 30,
   parameter int MAX_WORDS   = 784
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_start,
   input  logic        cfg_clear_err,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [31:0] config_in,
   output logic        config_valid,
   output logic        config_type,
   output logic [1:0]  config_layer_num,
   output logic [4:0]  config_neuron_num,
   output logic        cfg_busy,
   output logic        cfg_done,
   output logic        cfg_err,
   output logic [15:0] blocks_loaded
);

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      LOAD,
      DISCARD,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] remaining_q, remaining_d;
   logic [31:0] configIn_q, configIn_d;
   logic        configValid_q, configValid_d;
   logic        configType_q, configType_d;
   logic [1:0]  layerNum_q, layerNum_d;
   logic [4:0]  neuronNum_q, neuronNum_d;
   logic        err_q, err_d;
   logic [15:0] blocks_q, blocks_d;

   logic        beatAccepted;
   logic        errSet;
   logic        hdrType;
   logic [1:0]  hdrLayer;
   logic [4:0]  hdrNeuron;
   logic [7:0]  hdrOpcode;
   logic [15:0] hdrCount;
   logic        addrOk;
   logic        lenOk;
   logic        hdrError;

   assign s_ready      = (state_q == HDR) || (state_q == LOAD) || (state_q == DISCARD);
   assign beatAccepted = s_valid && s_ready;

   assign hdrType   = s_data[31];
   assign hdrLayer  = s_data[30:29];
   assign hdrNeuron = s_data[28:24];
   assign hdrOpcode = s_data[23:16];
   assign hdrCount  = s_data[15:0];

   assign addrOk   = ({30'd0, hdrLayer} < NUM_LAYERS) && ({27'd0, hdrNeuron} < NUM_NEURONS);
   assign lenOk    = ({16'd0, hdrCount} <= MAX_WORDS);
   // END headers are never errors; any other header must be a well-formed LOAD
   assign hdrError = (hdrOpcode != 8'hFF) && ((hdrOpcode != 8'h00) || !addrOk || !lenOk);

   always_comb begin
      state_d       = state_q;
      remaining_d   = remaining_q;
      configIn_d    = configIn_q;
      configValid_d = 1'b0;
      configType_d  = configType_q;
      layerNum_d    = layerNum_q;
      neuronNum_d   = neuronNum_q;
      blocks_d      = blocks_q;
      errSet        = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (cfg_start) begin
               state_d = HDR;
            end
         end
         HDR: begin
            if (beatAccepted) begin
               if (hdrOpcode == 8'hFF) begin
                  state_d = DONE;
               end else if (hdrError) begin
                  // Rejected blocks still carry their payload, which must be drained
                  errSet      = 1'b1;
                  remaining_d = hdrCount;
                  state_d     = (hdrCount != 16'd0) ? DISCARD : HDR;
               end else if (hdrCount != 16'd0) begin
                  configType_d = hdrType;
                  layerNum_d   = hdrLayer;
                  neuronNum_d  = hdrNeuron;
                  remaining_d  = hdrCount;
                  state_d      = LOAD;
               end
            end
         end
         LOAD: begin
            if (beatAccepted) begin
               configIn_d    = s_data;
               configValid_d = 1'b1;
               remaining_d   = remaining_q - 16'd1;
               if (remaining_q == 16'd1) begin
                  blocks_d = blocks_q + 16'd1;
                  state_d  = HDR;
               end
            end
         end
         DISCARD: begin
            if (beatAccepted) begin
               remaining_d = remaining_q - 16'd1;
               if (remaining_q == 16'd1) begin
                  state_d = HDR;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (errSet) begin
         err_d = 1'b1;
      end else if (cfg_clear_err) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         remaining_q   <= 16'd0;
         configIn_q    <= 32'd0;
         configValid_q <= 1'b0;
         configType_q  <= 1'b0;
         layerNum_q    <= 2'd0;
         neuronNum_q   <= 5'd0;
         err_q         <= 1'b0;
         blocks_q      <= 16'd0;
      end else begin
         state_q       <= state_d;
         remaining_q   <= remaining_d;
         configIn_q    <= configIn_d;
         configValid_q <= configValid_d;
         configType_q  <= configType_d;
         layerNum_q    <= layerNum_d;
         neuronNum_q   <= neuronNum_d;
         err_q         <= err_d;
         blocks_q      <= blocks_d;
      end
   end

   assign config_in         = configIn_q;
   assign config_valid      = configValid_q;
   assign config_type       = configType_q;
   assign config_layer_num  = layerNum_q;
   assign config_neuron_num = neuronNum_q;
   assign cfg_busy          = s_ready;
   assign cfg_done          = (state_q == DONE);
   assign cfg_err           = err_q;
   assign blocks_loaded     = blocks_q;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: loads, gaps, error discards, mid-block reset
// and two full-size blocks streamed back to back.
module tb_config_loader;

   logic        clk;
   logic        rst;
   logic        cfg_start;
   logic        cfg_clear_err;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] config_in;
   logic        config_valid;
   logic        config_type;
   logic [1:0]  config_layer_num;
   logic [4:0]  config_neuron_num;
   logic        cfg_busy;
   logic        cfg_done;
   logic        cfg_err;
   logic [15:0] blocks_loaded;

   int          errorCount = 0;
   int          checkCount = 0;
   int          cycleCount = 0;
   int          pulseCount = 0;
   int          firstPulseCycle = -1;
   int          lastPulseCycle = -1;
   logic [31:0] dataSum = 32'd0;

   config_loader dut (
      .clk               (clk),
      .rst               (rst),
      .cfg_start         (cfg_start),
      .cfg_clear_err     (cfg_clear_err),
      .s_data            (s_data),
      .s_valid           (s_valid),
      .s_ready           (s_ready),
      .config_in         (config_in),
      .config_valid      (config_valid),
      .config_type       (config_type),
      .config_layer_num  (config_layer_num),
      .config_neuron_num (config_neuron_num),
      .cfg_busy          (cfg_busy),
      .cfg_done          (cfg_done),
      .cfg_err           (cfg_err),
      .blocks_loaded     (blocks_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts config_valid pulses on the falling edge, well away from the active edge
   always @(negedge clk) begin
      cycleCount++;
      if (config_valid === 1'b1) begin
         pulseCount++;
         dataSum = dataSum + config_in;
         lastPulseCycle = cycleCount;
         if (firstPulseCycle < 0) firstPulseCycle = cycleCount;
      end
   end

   task automatic stepCycle();
      @(negedge clk);
      #1;
   endtask

   task automatic driveWord(input logic [31:0] d);
      s_valid = 1'b1;
      s_data  = d;
      stepCycle();
   endtask

   task automatic idleCycles(input int n);
      s_valid = 1'b0;
      repeat (n) stepCycle();
   endtask

   task automatic pulseStart();
      cfg_start = 1'b1;
      stepCycle();
      cfg_start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) stepCycle();
      checkCount++;
      if ({s_ready, config_valid, config_type, config_layer_num, config_neuron_num,
           cfg_busy, cfg_done, cfg_err} !== 13'd0) begin
         errorCount++;
         $display("[TB] FAIL reset_flags: got %b expected 0", {s_ready, config_valid, config_type,
                  config_layer_num, config_neuron_num, cfg_busy, cfg_done, cfg_err});
      end
      checkCount++;
      if (config_in !== 32'd0 || blocks_loaded !== 16'd0) begin
         errorCount++;
         $display("[TB] FAIL reset_data: got config_in=%h blocks=%0d expected 0/0", config_in, blocks_loaded);
      end
      rst = 1'b1;
      stepCycle();
   endtask

   task automatic test_basic_load();
      int base;
      pulseStart();
      checkCount++;
      if (s_ready !== 1'b1 || cfg_busy !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL start_ready: got s_ready=%b busy=%b expected 1/1", s_ready, cfg_busy);
      end
      base = pulseCount;
      driveWord({1'b0, 2'd1, 5'd3, 8'h00, 16'd3});
      driveWord(32'hA0A0_0001);
      checkCount++;
      if (config_valid !== 1'b1 || config_in !== 32'hA0A0_0001) begin
         errorCount++;
         $display("[TB] FAIL load_wordA: got v=%b data=%h expected 1/a0a00001", config_valid, config_in);
      end
      checkCount++;
      if ({config_type, config_layer_num, config_neuron_num} !== {1'b0, 2'd1, 5'd3}) begin
         errorCount++;
         $display("[TB] FAIL load_addr: got t=%b l=%0d n=%0d expected 0/1/3",
                  config_type, config_layer_num, config_neuron_num);
      end
      // A start pulse mid-block must not disturb the load
      cfg_start = 1'b1;
      driveWord(32'hB0B0_0002);
      cfg_start = 1'b0;
      checkCount++;
      if (config_valid !== 1'b1 || config_in !== 32'hB0B0_0002) begin
         errorCount++;
         $display("[TB] FAIL load_wordB: got v=%b data=%h expected 1/b0b00002", config_valid, config_in);
      end
      driveWord(32'hC0C0_0003);
      checkCount++;
      if (config_valid !== 1'b1 || config_in !== 32'hC0C0_0003 || blocks_loaded !== 16'd1) begin
         errorCount++;
         $display("[TB] FAIL load_wordC: got v=%b data=%h blocks=%0d expected 1/c0c00003/1",
                  config_valid, config_in, blocks_loaded);
      end
      idleCycles(1);
      checkCount++;
      if (config_valid !== 1'b0 || config_in !== 32'hC0C0_0003 || pulseCount - base !== 3) begin
         errorCount++;
         $display("[TB] FAIL load_after: got v=%b data=%h pulses=%0d expected 0/c0c00003/3",
                  config_valid, config_in, pulseCount - base);
      end
   endtask

   task automatic test_bias_gap_end();
      int base;
      base = pulseCount;
      driveWord({1'b1, 2'd0, 5'd29, 8'h00, 16'd1});
      idleCycles(2);
      checkCount++;
      if (config_valid !== 1'b0 || pulseCount !== base) begin
         errorCount++;
         $display("[TB] FAIL gap_quiet: got v=%b pulses=%0d expected 0/0", config_valid, pulseCount - base);
      end
      driveWord(32'h0000_1234);
      checkCount++;
      if (config_valid !== 1'b1 || config_in !== 32'h0000_1234 || config_type !== 1'b1 ||
          config_neuron_num !== 5'd29 || config_layer_num !== 2'd0) begin
         errorCount++;
         $display("[TB] FAIL bias_word: got v=%b data=%h t=%b l=%0d n=%0d expected 1/00001234/1/0/29",
                  config_valid, config_in, config_type, config_layer_num, config_neuron_num);
      end
      driveWord({1'b0, 2'd0, 5'd0, 8'hFF, 16'd0});
      s_valid = 1'b0;
      checkCount++;
      if (cfg_done !== 1'b1 || s_ready !== 1'b0 || cfg_busy !== 1'b0 || blocks_loaded !== 16'd2) begin
         errorCount++;
         $display("[TB] FAIL end_done: got done=%b ready=%b busy=%b blocks=%0d expected 1/0/0/2",
                  cfg_done, s_ready, cfg_busy, blocks_loaded);
      end
   endtask

   task automatic test_addr_error();
      int base;
      pulseStart();
      checkCount++;
      if (cfg_done !== 1'b0 || s_ready !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL restart: got done=%b ready=%b expected 0/1", cfg_done, s_ready);
      end
      base = pulseCount;
      driveWord({1'b0, 2'd2, 5'd30, 8'h00, 16'd4});
      checkCount++;
      if (cfg_err !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL neuron_err: got %b expected 1", cfg_err);
      end
      for (int i = 0; i < 4; i++) driveWord(32'hDEAD_0000 + i);
      driveWord({1'b0, 2'd2, 5'd7, 8'h00, 16'd2});
      driveWord(32'h0000_0011);
      driveWord(32'h0000_0022);
      idleCycles(1);
      checkCount++;
      if (pulseCount - base !== 2 || config_in !== 32'h0000_0022 || blocks_loaded !== 16'd3 ||
          config_layer_num !== 2'd2 || config_neuron_num !== 5'd7 || cfg_err !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL after_discard: got pulses=%0d data=%h blocks=%0d l=%0d n=%0d err=%b expected 2/00000022/3/2/7/1",
                  pulseCount - base, config_in, blocks_loaded, config_layer_num, config_neuron_num, cfg_err);
      end
      cfg_clear_err = 1'b1;
      stepCycle();
      cfg_clear_err = 1'b0;
      checkCount++;
      if (cfg_err !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL clear_err: got %b expected 0", cfg_err);
      end
      // Reserved opcode with N=0 arriving together with a clear: the error wins
      cfg_clear_err = 1'b1;
      driveWord({1'b0, 2'd0, 5'd0, 8'h5A, 16'd0});
      cfg_clear_err = 1'b0;
      s_valid = 1'b0;
      checkCount++;
      if (cfg_err !== 1'b1 || cfg_busy !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL err_wins: got err=%b busy=%b expected 1/1", cfg_err, cfg_busy);
      end
      cfg_clear_err = 1'b1;
      stepCycle();
      cfg_clear_err = 1'b0;
   endtask

   task automatic test_length_error();
      int base;
      base = pulseCount;
      driveWord({1'b0, 2'd0, 5'd0, 8'h00, 16'd785});
      checkCount++;
      if (cfg_err !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL len_err: got %b expected 1", cfg_err);
      end
      for (int i = 0; i < 785; i++) driveWord(32'h5000_0000 + i);
      driveWord({1'b0, 2'd1, 5'd1, 8'h00, 16'd0});
      s_valid = 1'b0;
      checkCount++;
      if (pulseCount !== base || s_ready !== 1'b1 || blocks_loaded !== 16'd3 ||
          config_layer_num !== 2'd2 || config_neuron_num !== 5'd7) begin
         errorCount++;
         $display("[TB] FAIL zero_len: got pulses=%0d ready=%b blocks=%0d l=%0d n=%0d expected 0/1/3/2/7",
                  pulseCount - base, s_ready, blocks_loaded, config_layer_num, config_neuron_num);
      end
      driveWord({1'b1, 2'd3, 5'd0, 8'h00, 16'd1});
      driveWord(32'h0000_7777);
      checkCount++;
      if (config_valid !== 1'b1 || config_in !== 32'h0000_7777 || config_layer_num !== 2'd3 ||
          blocks_loaded !== 16'd4) begin
         errorCount++;
         $display("[TB] FAIL top_layer: got v=%b data=%h l=%0d blocks=%0d expected 1/00007777/3/4",
                  config_valid, config_in, config_layer_num, blocks_loaded);
      end
      s_valid = 1'b0;
      cfg_clear_err = 1'b1;
      stepCycle();
      cfg_clear_err = 1'b0;
   endtask

   task automatic test_reset_mid_block();
      int base;
      driveWord({1'b0, 2'd1, 5'd1, 8'h00, 16'd5});
      driveWord(32'h1111_0001);
      driveWord(32'h1111_0002);
      s_valid = 1'b0;
      rst = 1'b0;
      #1;
      checkCount++;
      if (config_valid !== 1'b0 || blocks_loaded !== 16'd0 || s_ready !== 1'b0 || cfg_busy !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL mid_reset: got v=%b blocks=%0d ready=%b busy=%b expected 0/0/0/0",
                  config_valid, blocks_loaded, s_ready, cfg_busy);
      end
      stepCycle();
      rst = 1'b1;
      stepCycle();
      pulseStart();
      base = pulseCount;
      driveWord({1'b0, 2'd0, 5'd2, 8'h00, 16'd2});
      driveWord(32'h0000_00AA);
      driveWord(32'h0000_00BB);
      idleCycles(1);
      checkCount++;
      if (pulseCount - base !== 2 || config_in !== 32'h0000_00BB || blocks_loaded !== 16'd1 ||
          config_neuron_num !== 5'd2) begin
         errorCount++;
         $display("[TB] FAIL fresh_block: got pulses=%0d data=%h blocks=%0d n=%0d expected 2/000000bb/1/2",
                  pulseCount - base, config_in, blocks_loaded, config_neuron_num);
      end
   endtask

   task automatic test_back_to_back();
      int          base;
      logic [31:0] sumBase;
      logic [31:0] expectSum;
      logic [31:0] word;
      base            = pulseCount;
      sumBase         = dataSum;
      expectSum       = 32'd0;
      firstPulseCycle = -1;
      for (int b = 0; b < 2; b++) begin
         driveWord({1'b0, 2'd0, 5'(b), 8'h00, 16'd784});
         for (int i = 0; i < 784; i++) begin
            word      = {16'(b + 1), 16'(i)};
            expectSum = expectSum + word;
            driveWord(word);
         end
      end
      driveWord({1'b0, 2'd0, 5'd0, 8'hFF, 16'd0});
      s_valid = 1'b0;
      checkCount++;
      if (pulseCount - base !== 1568 || dataSum - sumBase !== expectSum) begin
         errorCount++;
         $display("[TB] FAIL b2b_count: got pulses=%0d sum=%h expected 1568/%h",
                  pulseCount - base, dataSum - sumBase, expectSum);
      end
      checkCount++;
      if (lastPulseCycle - firstPulseCycle + 1 !== 1569) begin
         errorCount++;
         $display("[TB] FAIL b2b_span: got %0d cycles expected 1569", lastPulseCycle - firstPulseCycle + 1);
      end
      checkCount++;
      if (blocks_loaded !== 16'd3 || cfg_done !== 1'b1 || config_neuron_num !== 5'd1) begin
         errorCount++;
         $display("[TB] FAIL b2b_done: got blocks=%0d done=%b n=%0d expected 3/1/1",
                  blocks_loaded, cfg_done, config_neuron_num);
      end
      pulseStart();
      checkCount++;
      if (cfg_done !== 1'b0 || cfg_busy !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL b2b_restart: got done=%b busy=%b expected 0/1", cfg_done, cfg_busy);
      end
   endtask

   initial begin
      rst           = 1'b0;
      cfg_start     = 1'b0;
      cfg_clear_err = 1'b0;
      s_valid       = 1'b0;
      s_data        = 32'd0;
      test_reset();
      test_basic_load();
      test_bias_gap_end();
      test_addr_error();
      test_length_error();
      test_reset_mid_block();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
